bus_arbiter_mm: RTL and testbench

- Parametrised, registered successor to the combinational data-bus arbiter and memory-map decoder.
- Arbitrates N_MASTERS bus masters (CPU, debug port, future DMA) onto one slave bus using round-robin with a forced-master override (debug halt).
- Decodes the address against a parameter table of N_SLAVES regions.
- Adds a per-transaction ready handshake, slave wait states, a timeout watchdog and decode-error reporting.

---
 rtl/bus_pkg.sv | 57 +++++
 rtl/bus_addr_decoder.sv | 32 +++
 rtl/bus_arbiter_mm.sv | 203 ++++++++++++++++++++
 tb/tb_bus_arbiter_mm.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings and default memory map for the bus arbiter
package bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Access mode; MODE_NONE means the slave must not act on the cycle.
    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    // Access width.
    localparam logic [1:0] REQW_BYTE = 2'b00;
    localparam logic [1:0] REQW_HALF = 2'b01;
    localparam logic [1:0] REQW_WORD = 2'b10;

    // Default memory map, inclusive bounds.
    localparam logic [31:0] PMEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] PMEM_LIMIT   = 32'h0000_1FFF;
    localparam logic [31:0] DMEM_BASE    = 32'h0000_2000;
    localparam logic [31:0] DMEM_LIMIT   = 32'h0000_3FFF;
    localparam logic [31:0] LEDS_BASE    = 32'h0000_4000;
    localparam logic [31:0] LEDS_LIMIT   = 32'h0000_4003;
    localparam logic [31:0] ICU_BASE     = 32'h0000_4010;
    localparam logic [31:0] ICU_LIMIT    = 32'h0000_401F;
    localparam logic [31:0] TIM1_BASE    = 32'h0000_4020;
    localparam logic [31:0] TIM1_LIMIT   = 32'h0000_402F;
    localparam logic [31:0] TIM2_BASE    = 32'h0000_4030;
    localparam logic [31:0] TIM2_LIMIT   = 32'h0000_403F;
    localparam logic [31:0] SYSTICK_BASE = 32'h0000_4040;
    localparam logic [31:0] SYSTICK_LIMIT= 32'h0000_404F;
    localparam logic [31:0] GPIO_BASE    = 32'h0000_4050;
    localparam logic [31:0] GPIO_LIMIT   = 32'h0000_405F;
    localparam logic [31:0] REGS_BASE    = 32'h0000_4100;
    localparam logic [31:0] REGS_LIMIT   = 32'h0000_41FF;

    localparam int NUM_DEFAULT_SLAVES = 9;

    // Region 0 sits in the least significant word.
    localparam logic [NUM_DEFAULT_SLAVES*32-1:0] DEFAULT_SLV_BASE = {
        REGS_BASE, GPIO_BASE, SYSTICK_BASE, TIM2_BASE, TIM1_BASE,
        ICU_BASE, LEDS_BASE, DMEM_BASE, PMEM_BASE
    };
    localparam logic [NUM_DEFAULT_SLAVES*32-1:0] DEFAULT_SLV_LIMIT = {
        REGS_LIMIT, GPIO_LIMIT, SYSTICK_LIMIT, TIM2_LIMIT, TIM1_LIMIT,
        ICU_LIMIT, LEDS_LIMIT, DMEM_LIMIT, PMEM_LIMIT
    };

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// rtl/bus_addr_decoder.sv - combinational address to one-hot slave select decoder
//
// Ports:
//   addr  in   32        address to decode
//   sel   out  N_SLAVES  one-hot select of the matching region (0 on miss)
//   hit   out  1         some region matched
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                        N_SLAVES  = NUM_DEFAULT_SLAVES,
    parameter logic [N_SLAVES*32-1:0]    SLV_BASE  = DEFAULT_SLV_BASE,
    parameter logic [N_SLAVES*32-1:0]    SLV_LIMIT = DEFAULT_SLV_LIMIT
) (
    input  logic [31:0]         addr,
    output logic [N_SLAVES-1:0] sel,
    output logic                hit
);

    // Scanning upward and stopping at the first match gives the lowest
    // region index priority when regions overlap.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!hit && region_hit(addr, SLV_BASE[i*32 +: 32], SLV_LIMIT[i*32 +: 32])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mm.sv
// rtl/bus_arbiter_mm.sv - registered round-robin bus arbiter with memory-map decode and watchdog
//
// Ports:
//   clk, reset_n               clock, async active-low reset
//   force_en, force_idx        debug-halt override: only force_idx may be granted
//   m_req/m_addr/m_wdata/      per-master request and access fields
//   m_reqw/m_mode/m_reqs
//   m_gnt                      one-hot grant, high while the transaction is in BUSY
//   m_done, m_err, m_rdata     registered completion pulse, error pulse, read data
//   s_addr/s_wdata/s_reqw/     slave bus fields of the granted master
//   s_mode/s_reqs/s_sel
//   s_rdata, s_ready           per-slave read data and completion
module bus_arbiter_mm
    import bus_pkg::*;
#(
    parameter int                     N_MASTERS = 2,
    parameter int                     N_SLAVES  = NUM_DEFAULT_SLAVES,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE  = DEFAULT_SLV_BASE,
    parameter logic [N_SLAVES*32-1:0] SLV_LIMIT = DEFAULT_SLV_LIMIT,
    parameter int                     TIMEOUT   = 15,
    parameter int                     MW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   force_en,
    input  logic [MW-1:0]          force_idx,
    input  logic [N_MASTERS-1:0]   m_req,
    input  logic [N_MASTERS*32-1:0] m_addr,
    input  logic [N_MASTERS*32-1:0] m_wdata,
    input  logic [N_MASTERS*2-1:0] m_reqw,
    input  logic [N_MASTERS*2-1:0] m_mode,
    input  logic [N_MASTERS-1:0]   m_reqs,
    output logic [N_MASTERS-1:0]   m_gnt,
    output logic [N_MASTERS-1:0]   m_done,
    output logic [N_MASTERS-1:0]   m_err,
    output logic [31:0]            m_rdata,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [1:0]             s_reqw,
    output logic [1:0]             s_mode,
    output logic                   s_reqs,
    output logic [N_SLAVES-1:0]    s_sel,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]    s_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e          state, state_next;
    logic [MW-1:0]       grant_idx;
    logic [MW-1:0]       last_grant;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;
    logic [1:0]          lat_reqw;
    logic [1:0]          lat_mode;
    logic                lat_reqs;
    logic [CW-1:0]       cnt;
    logic [N_MASTERS-1:0] done_q, err_q;
    logic [31:0]         rdata_q;

    logic                win;
    logic [MW-1:0]       win_idx;
    int                  rr_idx;
    logic                fin_ok, fin_err;
    logic [N_SLAVES-1:0] dec_sel;
    logic                dec_hit;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    bus_addr_decoder #(
        .N_SLAVES  (N_SLAVES),
        .SLV_BASE  (SLV_BASE),
        .SLV_LIMIT (SLV_LIMIT)
    ) u_decoder (
        .addr (lat_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign sel_ready = |(s_ready & dec_sel);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (dec_sel[i]) begin
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        win        = 1'b0;
        win_idx    = '0;
        rr_idx     = 0;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;
        m_gnt      = '0;
        s_addr     = '0;
        s_wdata    = '0;
        s_reqw     = '0;
        s_mode     = MODE_NONE;
        s_reqs     = 1'b0;
        s_sel      = '0;

        case (state)
            ST_IDLE: begin
                if (force_en) begin
                    // An out-of-range forced index leaves nobody eligible.
                    if ((int'(force_idx) < N_MASTERS) && m_req[force_idx]) begin
                        win     = 1'b1;
                        win_idx = force_idx;
                    end
                end else begin
                    for (int k = 1; k <= N_MASTERS; k++) begin
                        rr_idx = (int'(last_grant) + k) % N_MASTERS;
                        if (!win && m_req[rr_idx]) begin
                            win     = 1'b1;
                            win_idx = MW'(rr_idx);
                        end
                    end
                end
                if (win) begin
                    state_next = ST_BUSY;
                end
            end

            ST_BUSY: begin
                m_gnt   = N_MASTERS'(1) << grant_idx;
                s_addr  = lat_addr;
                s_wdata = lat_wdata;
                s_reqw  = lat_reqw;
                s_reqs  = lat_reqs;
                s_sel   = dec_sel;
                // A decode miss must never present a live mode to any slave.
                s_mode  = dec_hit ? lat_mode : MODE_NONE;
                if (!dec_hit) begin
                    fin_err = 1'b1;
                end else if (sel_ready) begin
                    fin_ok = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    fin_err = 1'b1;
                end
                if (fin_ok || fin_err) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_idx  <= '0;
            last_grant <= MW'(N_MASTERS - 1);
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_reqw   <= '0;
            lat_mode   <= MODE_NONE;
            lat_reqs   <= 1'b0;
            cnt        <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (state == ST_IDLE && win) begin
                grant_idx <= win_idx;
                lat_addr  <= m_addr[int'(win_idx)*32 +: 32];
                lat_wdata <= m_wdata[int'(win_idx)*32 +: 32];
                lat_reqw  <= m_reqw[int'(win_idx)*2 +: 2];
                lat_mode  <= m_mode[int'(win_idx)*2 +: 2];
                lat_reqs  <= m_reqs[win_idx];
            end
            if (state == ST_BUSY) begin
                if (fin_ok || fin_err) begin
                    cnt        <= '0;
                    last_grant <= grant_idx;
                    done_q     <= N_MASTERS'(1) << grant_idx;
                    err_q      <= fin_err ? (N_MASTERS'(1) << grant_idx) : '0;
                    rdata_q    <= fin_ok ? sel_rdata : 32'h0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign m_done  = done_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter_mm.sv
// tb/tb_bus_arbiter_mm.sv - self-checking bench for bus_arbiter_mm
module tb_bus_arbiter_mm;
    import bus_pkg::*;

    localparam int NM = 2;
    localparam int NS = NUM_DEFAULT_SLAVES;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              force_en;
    logic [0:0]        force_idx;
    logic [NM-1:0]     m_req;
    logic [NM*32-1:0]  m_addr, m_wdata;
    logic [NM*2-1:0]   m_reqw, m_mode;
    logic [NM-1:0]     m_reqs;
    logic [NM-1:0]     m_gnt, m_done, m_err;
    logic [31:0]       m_rdata, s_addr, s_wdata;
    logic [1:0]        s_reqw, s_mode;
    logic              s_reqs;
    logic [NS-1:0]     s_sel;
    logic [NS*32-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;

    logic [31:0]       sdata [NS];
    logic [NS*32-1:0]  map_base  = DEFAULT_SLV_BASE;
    logic [NS*32-1:0]  map_limit = DEFAULT_SLV_LIMIT;

    int checks = 0;
    int errors = 0;
    int last_model;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = sdata[i];
    end

    bus_arbiter_mm #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .SLV_BASE  (DEFAULT_SLV_BASE),
        .SLV_LIMIT (DEFAULT_SLV_LIMIT),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .force_en  (force_en),
        .force_idx (force_idx),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_reqw    (m_reqw),
        .m_mode    (m_mode),
        .m_reqs    (m_reqs),
        .m_gnt     (m_gnt),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_reqw    (s_reqw),
        .s_mode    (s_mode),
        .s_reqs    (s_reqs),
        .s_sel     (s_sel),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready)
    );

    typedef struct {
        logic        fe;
        logic        fi;
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic [1:0]  md0, md1;
        int          w;       // BUSY cycles before the slave raises ready
        int          win;     // -1: nobody granted
        int          hit;     // -1: decode miss
        logic        err;
        int          done_c;  // cycle carrying m_done (cycle 0 = request)
        logic [31:0] rd;
    } ep_t;

    ep_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic ep_t mk(input logic fe, input logic fi, input logic [1:0] req,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [1:0] md0, input logic [1:0] md1, input int w,
                               input int win, input int hit, input logic err,
                               input int done_c, input logic [31:0] rd);
        ep_t e;
        e.fe = fe; e.fi = fi; e.req = req; e.a0 = a0; e.a1 = a1;
        e.md0 = md0; e.md1 = md1; e.w = w; e.win = win; e.hit = hit;
        e.err = err; e.done_c = done_c; e.rd = rd;
        return e;
    endfunction

    function automatic int map_lookup(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= map_base[i*32 +: 32] && a <= map_limit[i*32 +: 32]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int i, k;
        logic [31:0] b, l;
        i = $urandom_range(NS - 1, 0);
        k = $urandom_range(4, 0);
        b = map_base[i*32 +: 32];
        l = map_limit[i*32 +: 32];
        case (k)
            0: return b;
            1: return l;
            2: return b + ($urandom % (l - b + 1));
            3: return 32'h5000 + 32'($urandom_range(255, 0));
            default: return l + 1;
        endcase
    endfunction

    // Transaction-level expectation from the arbitration and timing rules.
    function automatic ep_t predict(input ep_t e);
        ep_t r;
        r = e;
        r.win = -1;
        if (e.fe) begin
            if (e.req[e.fi]) r.win = int'(e.fi);
        end else begin
            for (int k = 1; k <= NM; k++) begin
                if (r.win < 0 && e.req[(last_model + k) % NM]) r.win = (last_model + k) % NM;
            end
        end
        r.hit = -1; r.err = 1'b0; r.rd = 32'h0; r.done_c = 3;
        if (r.win >= 0) begin
            r.hit = map_lookup(r.win == 1 ? e.a1 : e.a0);
            if (r.hit < 0) begin
                r.err = 1'b1; r.done_c = 2;
            end else if (e.w < TO) begin
                r.done_c = 2 + e.w; r.rd = sdata[r.hit];
            end else begin
                r.err = 1'b1; r.done_c = TO + 1;
            end
            last_model = r.win;
        end
        return r;
    endfunction

    task automatic run_ep(input string nm, input ep_t e);
        logic [31:0] wd0, wd1, wa, wdx;
        logic [1:0]  wm, goh;
        logic [NS-1:0] sel_exp;
        wd0 = $urandom; wd1 = $urandom;
        wa  = (e.win == 1) ? e.a1 : e.a0;
        wdx = (e.win == 1) ? wd1 : wd0;
        wm  = (e.win == 1) ? e.md1 : e.md0;
        goh = (e.win < 0) ? 2'b00 : (2'b01 << e.win);
        sel_exp = (e.hit < 0) ? '0 : (NS'(1) << e.hit);
        for (int c = 0; c <= e.done_c; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                force_en = e.fe; force_idx = e.fi; m_req = e.req;
                m_addr = {e.a1, e.a0}; m_wdata = {wd1, wd0}; m_mode = {e.md1, e.md0};
                m_reqw = 4'($urandom); m_reqs = 2'($urandom);
            end
            s_ready = (c >= 1 + e.w) ? '1 : '0;
            if (c == e.done_c) m_req = '0;
            @(negedge clk);
            if (c == e.done_c && e.win >= 0) begin
                chk({nm, " done"}, 32'(m_done), 32'(goh));
                chk({nm, " err"}, 32'(m_err), e.err ? 32'(goh) : 32'h0);
                chk({nm, " rdata"}, m_rdata, e.rd);
                chk({nm, " gnt_end"}, 32'(m_gnt), 32'h0);
            end else if (c > 0 && e.win >= 0) begin
                chk({nm, " gnt"}, 32'(m_gnt), 32'(goh));
                chk({nm, " done_early"}, 32'(m_done), 32'h0);
                chk({nm, " sel"}, 32'(s_sel), 32'(sel_exp));
                chk({nm, " mode"}, 32'(s_mode), (e.hit < 0) ? 32'h0 : 32'(wm));
                chk({nm, " addr"}, s_addr, wa);
                chk({nm, " wdata"}, s_wdata, wdx);
            end else begin
                chk({nm, " gnt_idle"}, 32'(m_gnt), 32'h0);
                chk({nm, " sel_idle"}, 32'(s_sel), 32'h0);
                chk({nm, " mode_idle"}, 32'(s_mode), 32'h0);
                chk({nm, " done_idle"}, 32'(m_done), 32'h0);
            end
        end
    endtask

    initial begin
        logic [1:0] exp_g, prev_g;
        ep_t e;
        reset_n = 1'b0; force_en = 1'b0; force_idx = '0; m_req = '0;
        m_addr = '0; m_wdata = '0; m_reqw = '0; m_mode = '0; m_reqs = '0; s_ready = '0;
        for (int i = 0; i < NS; i++) sdata[i] = 32'hDEADBEEE ^ 32'(i);

        tbl[0]  = mk(0, 0, 2'b01, 32'h3004, 32'h0,    MODE_READ, MODE_NONE,  0,  0,  1, 0,  2, 32'hDEADBEEF);
        tbl[1]  = mk(0, 0, 2'b11, 32'h0100, 32'h4000, MODE_READ, MODE_READ,  0,  1,  2, 0,  2, 32'hDEADBEEC);
        tbl[2]  = mk(0, 0, 2'b11, 32'h0100, 32'h4000, MODE_READ, MODE_READ,  0,  0,  0, 0,  2, 32'hDEADBEEE);
        tbl[3]  = mk(1, 1, 2'b11, 32'h0100, 32'h4000, MODE_READ, MODE_READ,  0,  1,  2, 0,  2, 32'hDEADBEEC);
        tbl[4]  = mk(1, 1, 2'b11, 32'h0100, 32'h4000, MODE_READ, MODE_READ,  0,  1,  2, 0,  2, 32'hDEADBEEC);
        tbl[5]  = mk(1, 1, 2'b01, 32'h0100, 32'h4000, MODE_READ, MODE_READ,  0, -1, -1, 0,  3, 32'h0);
        tbl[6]  = mk(0, 0, 2'b11, 32'h4100, 32'h4000, MODE_READ, MODE_READ,  3,  0,  8, 0,  5, 32'hDEADBEE6);
        tbl[7]  = mk(0, 0, 2'b10, 32'h0100, 32'h5000, MODE_READ, MODE_WRITE, 0,  1, -1, 1,  2, 32'h0);
        tbl[8]  = mk(0, 0, 2'b01, 32'h2000, 32'h0,    MODE_READ, MODE_READ, 20,  0,  1, 1, 16, 32'h0);
        tbl[9]  = mk(0, 0, 2'b01, 32'h1FFF, 32'h0,    MODE_READ, MODE_READ, 14,  0,  0, 0, 16, 32'hDEADBEEE);
        tbl[10] = mk(0, 0, 2'b01, 32'h4003, 32'h0,    MODE_READ, MODE_READ, 15,  0,  2, 1, 16, 32'h0);
        tbl[11] = mk(0, 0, 2'b01, 32'h4004, 32'h0,    MODE_READ, MODE_READ,  0,  0, -1, 1,  2, 32'h0);
        tbl[12] = mk(0, 0, 2'b01, 32'h3004, 32'h0,    MODE_NONE, MODE_READ,  1,  0,  1, 0,  3, 32'hDEADBEEF);
        tbl[13] = mk(0, 0, 2'b11, 32'h0100, 32'h4055, MODE_READ, MODE_READ,  2,  1,  7, 0,  4, 32'hDEADBEE9);

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst gnt", 32'(m_gnt), 32'h0);
        chk("rst done", 32'(m_done), 32'h0);
        chk("rst err", 32'(m_err), 32'h0);
        chk("rst rdata", m_rdata, 32'h0);
        chk("rst sel", 32'(s_sel), 32'h0);
        chk("rst mode", 32'(s_mode), 32'h0);
        chk("rst addr", s_addr, 32'h0);

        for (int t = 0; t < 14; t++) run_ep($sformatf("vec%0d", t), tbl[t]);

        // Reset while a transaction is stuck waiting on its slave.
        @(posedge clk); #1;
        force_en = 1'b0; m_req = 2'b01; m_addr = {32'h0, 32'h3004}; m_mode = {2'b00, MODE_WRITE}; s_ready = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy pre_gnt", 32'(m_gnt), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstbusy gnt", 32'(m_gnt), 32'h0);
        chk("rstbusy sel", 32'(s_sel), 32'h0);
        chk("rstbusy mode", 32'(s_mode), 32'h0);
        m_req = '0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rstbusy idle", 32'(m_gnt), 32'h0);

        // Held requests: alternate, then force master 1 for ten transactions, then release.
        s_ready = '1; m_addr = {32'h4000, 32'h3004}; m_mode = {MODE_READ, MODE_READ};
        prev_g = 2'b00;
        for (int c = 0; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 0) m_req = 2'b11;
            force_en = (c >= 8 && c < 28);
            force_idx = 1'b1;
            if (c == 30) m_req = '0;
            @(negedge clk);
            if (c % 2 == 1) begin
                if (c < 8) exp_g = (c % 4 == 1) ? 2'b01 : 2'b10;
                else       exp_g = (c < 29) ? 2'b10 : 2'b01;
                chk($sformatf("rr gnt c%0d", c), 32'(m_gnt), 32'(exp_g));
                chk($sformatf("rr nodone c%0d", c), 32'(m_done), 32'h0);
                prev_g = exp_g;
            end else if (c > 0) begin
                chk($sformatf("rr done c%0d", c), 32'(m_done), 32'(prev_g));
                chk($sformatf("rr gap c%0d", c), 32'(m_gnt), 32'h0);
            end
        end
        force_en = 1'b0;

        last_model = 0;
        for (int t = 0; t < 150; t++) begin
            e.fe  = ($urandom_range(3, 0) == 0);
            e.fi  = 1'($urandom_range(1, 0));
            e.req = 2'($urandom_range(3, 1));
            e.a0  = rnd_addr();
            e.a1  = rnd_addr();
            e.md0 = 2'($urandom);
            e.md1 = 2'($urandom);
            e.w   = $urandom_range(TO + 2, 0);
            for (int i = 0; i < NS; i++) sdata[i] = $urandom;
            e = predict(e);
            run_ep($sformatf("rnd%0d", t), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
